// File: rtl/data_mem_responder.sv
// Memory-side responder modelling slow main memory for the data cache:
// one request in flight, programmable access latency, one-cycle completion pulse.
module data_mem_responder #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 12,
    parameter int LATENCY   = 2
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             mem_req_i,
    input  logic             mem_write_enable_i,
    input  logic             mem_byte_op_i,
    input  logic [WIDTH-1:0] mem_address_i,
    input  logic [WIDTH-1:0] mem_write_data_i,
    output logic             mem_ready_o,
    output logic             mem_valid_o,
    output logic [WIDTH-1:0] mem_read_data_o
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                 state, state_next;
    logic [3:0]             cnt, cnt_next;
    logic                   accept, commit;
    logic                   we_q, byte_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [WIDTH-1:0]       wdata_q, rdata_q;

    logic [WIDTH-1:0]       ram [0:2**(ADDR_BITS-2)-1];
    logic [ADDR_BITS-3:0]   idx;
    logic [4:0]             lane_bit;
    logic [WIDTH-1:0]       ram_word;
    logic [7:0]             lane_byte;

    // Address bits above the decoded range alias and are intentionally dropped.
    logic                   unused_addr_hi;
    assign unused_addr_hi = ^mem_address_i[WIDTH-1:ADDR_BITS];

    assign idx       = addr_q[ADDR_BITS-1:2];
    assign lane_bit  = {addr_q[1:0], 3'b000};
    assign ram_word  = ram[idx];
    assign lane_byte = ram_word[lane_bit +: 8];

    assign mem_ready_o     = (state == IDLE);
    assign mem_valid_o     = (state == RESP);
    assign mem_read_data_o = rdata_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req_i) begin
                    accept     = 1'b1;
                    cnt_next   = 4'(LATENCY - 1);
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    commit     = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                we_q    <= mem_write_enable_i;
                byte_q  <= mem_byte_op_i;
                addr_q  <= mem_address_i[ADDR_BITS-1:0];
                wdata_q <= mem_write_data_i;
            end
            if (commit && !we_q) begin
                rdata_q <= byte_q ? {{(WIDTH-8){1'b0}}, lane_byte} : ram_word;
            end
        end
    end

    // RAM is not reset, but a reset on the commit edge must still suppress the write.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && commit && we_q) begin
            if (byte_q) begin
                ram[idx][lane_bit +: 8] <= wdata_q[7:0];
            end else begin
                ram[idx] <= wdata_q;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected responses are queued at
// request time and compared when the completion pulse arrives.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, bt;
    logic [31:0] addr, wdata;
    logic        ready, valid;
    logic [31:0] rdata;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          vcnt     = 0;
    int          nreq     = 0;

    logic [31:0] exp_q [$];
    logic [31:0] model [0:1023];
    logic [31:0] last_rd = '0;

    data_mem_responder #(.WIDTH(32), .ADDR_BITS(12), .LATENCY(LAT)) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .mem_req_i          (req),
        .mem_write_enable_i (we),
        .mem_byte_op_i      (bt),
        .mem_address_i      (addr),
        .mem_write_data_i   (wdata),
        .mem_ready_o        (ready),
        .mem_valid_o        (valid),
        .mem_read_data_o    (rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && valid) vcnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drive a request, wait for acceptance, update the model; returns one
    // negedge after the accept edge with the request dropped.
    task automatic issue(input logic w, input logic b, input logic [31:0] a,
                         input logic [31:0] d, input bit track, input string tag);
        int          waited = 0;
        logic [9:0]  i;
        logic [4:0]  lb;
        @(negedge clk);
        check({tag, "_valid_low"}, {31'b0, valid}, 32'd0);
        req = 1'b1; we = w; bt = b; addr = a; wdata = d;
        while (!ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_ready_wait"}, 32'(waited), 32'd0);
        if (track) begin
            i  = a[11:2];
            lb = {a[1:0], 3'b000};
            if (w) begin
                if (b) model[i][lb +: 8] = d[7:0];
                else   model[i] = d;
            end else begin
                last_rd = b ? {24'b0, model[i][lb +: 8]} : model[i];
            end
            exp_q.push_back(last_rd);
        end
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = $urandom; bt = $urandom; addr = $urandom; wdata = $urandom;
    endtask

    // Wait for the completion pulse, checking latency, busy window and data.
    task automatic complete(input string tag);
        int          n = 0;
        bit          busy_ok = 1'b1;
        logic [31:0] e;
        while (!valid && n < 20) begin
            if (ready) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(LAT));
        check({tag, "_ready_busy"}, {31'b0, busy_ok && !ready}, 32'd1);
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_rdata"}, rdata, e);
        end
        nreq++;
    endtask

    initial begin
        int          snap;
        logic [31:0] raddr [0:5];

        rst_n = 1'b0; req = 1'b1; we = 1'b1; bt = 1'b0;
        addr = 32'h40; wdata = 32'hCAFEF00D;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_ready", {31'b0, ready}, 32'd1);
            check("rst_valid", {31'b0, valid}, 32'd0);
            check("rst_rdata", rdata, 32'd0);
        end
        rst_n = 1'b1; req = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'b0, ready}, 32'd1);

        issue(1'b1, 1'b0, 32'h040, 32'hDEADBEEF, 1'b1, "wr_word");
        complete("wr_word");
        issue(1'b0, 1'b0, 32'h040, 32'h0, 1'b1, "rd_word");
        complete("rd_word");
        check("rd_word_value", rdata, 32'hDEADBEEF);

        issue(1'b1, 1'b0, 32'h080, 32'h11223344, 1'b1, "byte_setup");
        complete("byte_setup");
        issue(1'b1, 1'b1, 32'h082, 32'h555555AA, 1'b1, "wr_byte");
        complete("wr_byte");
        check("wr_byte_holds_rdata", rdata, 32'hDEADBEEF);
        issue(1'b0, 1'b0, 32'h080, 32'h0, 1'b1, "rd_after_byte");
        complete("rd_after_byte");
        check("merged_word", rdata, 32'h11AA3344);
        issue(1'b0, 1'b1, 32'h082, 32'h0, 1'b1, "rd_byte2");
        complete("rd_byte2");
        check("byte2_value", rdata, 32'h000000AA);
        issue(1'b0, 1'b1, 32'h081, 32'h0, 1'b1, "rd_byte1");
        complete("rd_byte1");

        // Second request held while the first is still in flight.
        issue(1'b1, 1'b0, 32'h100, 32'hA5A5A5A5, 1'b1, "busy_a");
        req = 1'b1; we = 1'b0; bt = 1'b0; addr = 32'h100; wdata = 32'h0;
        complete("busy_a");
        issue(1'b0, 1'b0, 32'h100, 32'h0, 1'b1, "busy_b");
        complete("busy_b");

        issue(1'b1, 1'b0, 32'h1004, 32'h5, 1'b1, "alias_wr");
        complete("alias_wr");
        issue(1'b0, 1'b0, 32'h004, 32'h0, 1'b1, "alias_rd");
        complete("alias_rd");
        check("alias_value", rdata, 32'h5);

        issue(1'b1, 1'b0, 32'h010, 32'h12345678, 1'b1, "old_wr");
        complete("old_wr");
        issue(1'b1, 1'b0, 32'h010, 32'h77, 1'b0, "drop_wr");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_rd = '0;
        #1 snap = vcnt;
        check("drop_ready", {31'b0, ready}, 32'd1);
        check("drop_rdata", rdata, 32'd0);
        repeat (5) @(negedge clk);
        #1 check("drop_no_valid", 32'(vcnt), 32'(snap));
        issue(1'b0, 1'b0, 32'h010, 32'h0, 1'b1, "drop_rd");
        complete("drop_rd");
        check("drop_old_value", rdata, 32'h12345678);

        for (int k = 0; k < 6; k++) begin
            raddr[k] = 32'h200 + 32'(k * 12) + 32'($urandom_range(0, 3));
            issue(1'b1, 1'b0, raddr[k], $urandom, 1'b1, "rand_wr");
            complete("rand_wr");
        end
        for (int k = 0; k < 6; k++) begin
            issue(1'b0, 1'($urandom_range(0, 1)), raddr[k], 32'h0, 1'b1, "rand_rd");
            complete("rand_rd");
        end

        repeat (3) @(negedge clk);
        #1 check("valid_count", 32'(vcnt), 32'(nreq));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
